// File: rtl/decode_block_if.sv
// decode_block_if: fetch -> decode -> execute handshake bundle.
//   fetch_valid/fetch_ready/fetch_pipe/fetch_pc : raw instruction word from fetch
//   dec_valid/dec_ready/dec_*                    : decoded entry toward execute
// Modports:
//   slave  - the decode stage (consumes fetch words, produces dec_* entries)
//   master - the surrounding pipeline (fetch producer + execute consumer)
interface decode_block_if #(
   parameter int PC_W = 6
);
   logic            fetch_valid;
   logic            fetch_ready;
   logic [31:0]     fetch_pipe;
   logic [PC_W-1:0] fetch_pc;

   logic            dec_valid;
   logic            dec_ready;
   logic [PC_W-1:0] dec_pc;
   logic [6:0]      dec_opcode;
   logic [4:0]      dec_rd;
   logic [4:0]      dec_rs1;
   logic [4:0]      dec_rs2;
   logic [2:0]      dec_funct3;
   logic [6:0]      dec_funct7;
   logic [31:0]     dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;

   modport slave (
      input  fetch_valid, fetch_pipe, fetch_pc, dec_ready,
      output fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
             dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_fmt, dec_illegal
   );

   modport master (
      output fetch_valid, fetch_pipe, fetch_pc, dec_ready,
      input  fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
             dec_rs2, dec_funct3, dec_funct7, dec_imm, dec_fmt, dec_illegal
   );
endinterface

// File: rtl/decode_block.sv
// decode_block: RV32I decode stage with a registered two-entry skid buffer.
// Ports:
//   clk   - sole clock, rising edge
//   rst   - asynchronous active-high reset
//   flush - synchronous discard of all buffered entries
//   bus   - decode_block_if.slave (fetch_* in, dec_* out)
// Build option: define DECODE_RV32M_EN to accept the OP funct7=0000001 (M) group.
//
// state    | meaning
// ST_EMPTY | no entry held, dec_valid low
// ST_ONE   | output register holds one entry
// ST_TWO   | output and skid registers both full, fetch_ready low
module decode_block #(
   parameter int PC_W = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   decode_block_if.slave bus
);
   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_BAD = 3'd7;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     inst;
      logic [31:0]     imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   state_t state_q, state_d;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   entry_t fetch_ent;

   logic        fetch_ready;
   logic        accept;
   logic        drain;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [2:0]  fmt_raw;
   logic        legal;
   logic [31:0] imm_raw;

   assign op = bus.fetch_pipe[6:0];
   assign f3 = bus.fetch_pipe[14:12];
   assign f7 = bus.fetch_pipe[31:25];

   always_comb begin
      legal   = 1'b0;
      fmt_raw = FMT_BAD;
      // Every listed opcode ends in 2'b11, so an unlisted opcode also covers inst[1:0] != 11.
      case (op)
         7'b0110011: begin
            fmt_raw = FMT_R;
            legal   = (f7 == 7'b0000000) ||
                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
`ifdef DECODE_RV32M_EN
            if (f7 == 7'b0000001) legal = 1'b1;
`endif
         end
         7'b0000011: begin
            fmt_raw = FMT_I;
            legal   = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
         end
         7'b0010011: begin
            fmt_raw = FMT_I;
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   legal = 1'b1;
         end
         7'b1100111: begin
            fmt_raw = FMT_I;
            legal   = (f3 == 3'b000);
         end
         7'b0001111, 7'b1110011: begin
            fmt_raw = FMT_I;
            legal   = 1'b1;
         end
         7'b0100011: begin
            fmt_raw = FMT_S;
            legal   = (f3 < 3'b011);
         end
         7'b1100011: begin
            fmt_raw = FMT_B;
            legal   = !((f3 == 3'b010) || (f3 == 3'b011));
         end
         7'b0110111, 7'b0010111: begin
            fmt_raw = FMT_U;
            legal   = 1'b1;
         end
         7'b1101111: begin
            fmt_raw = FMT_J;
            legal   = 1'b1;
         end
         default: begin
            fmt_raw = FMT_BAD;
            legal   = 1'b0;
         end
      endcase
      if (bus.fetch_pipe[1:0] != 2'b11) legal = 1'b0;
   end

   always_comb begin
      imm_raw = 32'd0;
      case (fmt_raw)
         FMT_I: imm_raw = {{20{bus.fetch_pipe[31]}}, bus.fetch_pipe[31:20]};
         FMT_S: imm_raw = {{20{bus.fetch_pipe[31]}}, bus.fetch_pipe[31:25],
                           bus.fetch_pipe[11:7]};
         FMT_B: imm_raw = {{19{bus.fetch_pipe[31]}}, bus.fetch_pipe[31], bus.fetch_pipe[7],
                           bus.fetch_pipe[30:25], bus.fetch_pipe[11:8], 1'b0};
         FMT_U: imm_raw = {bus.fetch_pipe[31:12], 12'd0};
         FMT_J: imm_raw = {{11{bus.fetch_pipe[31]}}, bus.fetch_pipe[31], bus.fetch_pipe[19:12],
                           bus.fetch_pipe[20], bus.fetch_pipe[30:21], 1'b0};
         default: imm_raw = 32'd0;
      endcase
   end

   always_comb begin
      fetch_ent.pc      = bus.fetch_pc;
      fetch_ent.inst    = bus.fetch_pipe;
      fetch_ent.illegal = !legal;
      fetch_ent.fmt     = legal ? fmt_raw : FMT_BAD;
      fetch_ent.imm     = legal ? imm_raw : 32'd0;
   end

   // fetch_ready is a function of state and rst only; no path from dec_ready.
   assign fetch_ready = (state_q != ST_TWO) && !rst;
   assign accept      = bus.fetch_valid && fetch_ready;
   assign drain       = (state_q != ST_EMPTY) && bus.dec_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               out_d   = fetch_ent;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               out_d = fetch_ent;
            end else if (accept) begin
               state_d = ST_TWO;
               skid_d  = fetch_ent;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               state_d = ST_ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Data registers keep stale contents on flush; dec_valid gates them.
      if (flush) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   assign bus.fetch_ready = fetch_ready;
   assign bus.dec_valid   = (state_q != ST_EMPTY);
   assign bus.dec_pc      = out_q.pc;
   assign bus.dec_opcode  = out_q.inst[6:0];
   assign bus.dec_rd      = out_q.inst[11:7];
   assign bus.dec_rs1     = out_q.inst[19:15];
   assign bus.dec_rs2     = out_q.inst[24:20];
   assign bus.dec_funct3  = out_q.inst[14:12];
   assign bus.dec_funct7  = out_q.inst[31:25];
   assign bus.dec_imm     = out_q.imm;
   assign bus.dec_fmt     = out_q.fmt;
   assign bus.dec_illegal = out_q.illegal;
endmodule
